// File: rtl/regfile_past_pkg.sv
// -----------------------------------------------------------------------------
// regfile_past_pkg
//   Shared types and helpers for the regfile_past_pipe block.
//   - rf_state_e : controller states (CLEAR while wiping storage, RUN after)
//   - idx_w()    : index width needed to address 'depth' entries (min 1 bit)
// -----------------------------------------------------------------------------
package regfile_past_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

    // Smallest w such that 2**w >= depth, never below 1 so a 2-entry file
    // still gets a real index bit.
    function automatic int idx_w(input int depth);
        int w;
        w = 32'sd1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 << i) < depth) begin
                w = i + 32'sd1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_past_pipe_past_shift.sv
// -----------------------------------------------------------------------------
// past_shift
//   History pipeline: slice k-1 of past_data holds din from k cycles ago, and
//   past_valid bit k-1 rises once k cycles have passed since reset release.
//   Reset (synchronous, active-low) flushes both to zero.
// Ports
//   clk        in   clock
//   rst_n      in   synchronous active-low reset
//   din        in   WIDTH     value to record this cycle
//   past_data  out  HIST*WIDTH delayed copies of din
//   past_valid out  HIST      per-slice validity, saturates at all ones
// -----------------------------------------------------------------------------
module past_shift #(
    parameter int WIDTH = 8,
    parameter int HIST  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      din,
    output logic [HIST*WIDTH-1:0] past_data,
    output logic [HIST-1:0]       past_valid
);

    logic [HIST*WIDTH-1:0] data_d, data_q;
    logic [HIST-1:0]       valid_d, valid_q;

    // Next history: shift one slice deeper and pull a 1 into the valid chain.
    always_comb begin
        data_d              = data_q;
        valid_d             = valid_q;
        data_d[0 +: WIDTH]  = din;
        valid_d[0]          = 1'b1;
        for (int k = 1; k < HIST; k++) begin
            data_d[k*WIDTH +: WIDTH] = data_q[(k-1)*WIDTH +: WIDTH];
            valid_d[k]               = valid_q[k-1];
        end
    end

    // History registers, flushed by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign past_data  = data_q;
    assign past_valid = valid_q;

endmodule

// File: rtl/regfile_past_pipe.sv
// -----------------------------------------------------------------------------
// regfile_past_pipe
//   Register file that wipes itself after reset (one entry per cycle, DEPTH
//   cycles), one write port, one combinational read port, and a HIST-deep
//   history of read values (past_data[k-1] == rd_data delayed k cycles).
// Ports
//   clk, rst_n  clock, synchronous active-low reset
//   wr_valid/wr_ready/wr_idx/wr_data  write handshake; ready low while clearing
//   rd_idx/rd_data                    combinational read, 0 for idx >= DEPTH
//   past_data/past_valid              read history and its validity
//   clr_busy                          high while the clear sweep runs
// Build option
//   REGFILE_PAST_FORMAL_EN : compiles in immediate assume/assert/cover
//   statements (labels m_idx, a_rdy, a_wr, a_hist, c_last). Functional
//   behaviour is the same with or without it.
// -----------------------------------------------------------------------------
module regfile_past_pipe
    import regfile_past_pkg::*;
#(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    parameter  int HIST  = 2,
    localparam int IDX_W = idx_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [WIDTH-1:0]      rd_data,
    output logic [HIST*WIDTH-1:0] past_data,
    output logic [HIST-1:0]       past_valid,
    output logic                  clr_busy
);

    // Pointer is one bit wider than the index so it never wraps.
    localparam logic [IDX_W:0] LAST_PTR = (IDX_W+1)'(DEPTH - 1);
    localparam logic [IDX_W:0] PTR_ONE  = (IDX_W+1)'(1);

    rf_state_e        state_d, state_q;
    logic [IDX_W:0]   clr_ptr_d, clr_ptr_q;
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic             wr_fire_s;
    logic [WIDTH-1:0] rd_data_s;

    // Controller state and clear pointer; reset restarts the sweep at entry 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Next state: sweep every entry once, then stay in RUN until reset.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            CLEAR: begin
                clr_ptr_d = clr_ptr_q + PTR_ONE;
                if (clr_ptr_q == LAST_PTR) begin
                    state_d = RUN;
                end else begin
                    state_d = CLEAR;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d   = CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    // Handshake/status outputs decoded from the state flop.
    always_comb begin
        wr_ready = 1'b0;
        clr_busy = 1'b1;
        case (state_q)
            CLEAR: begin
                wr_ready = 1'b0;
                clr_busy = 1'b1;
            end
            RUN: begin
                wr_ready = 1'b1;
                clr_busy = 1'b0;
            end
            default: begin
                wr_ready = 1'b0;
                clr_busy = 1'b1;
            end
        endcase
    end

    assign wr_fire_s = wr_valid && wr_ready;

    // Storage update: clear one entry per CLEAR cycle, otherwise take the
    // accepted write. Out-of-range write indices match no entry and vanish.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < DEPTH; i++) begin
            if ((state_q == CLEAR) && (clr_ptr_q == (IDX_W+1)'(i))) begin
                regs_d[i] = '0;
            end else if ((state_q == RUN) && wr_fire_s && (wr_idx == IDX_W'(i))) begin
                regs_d[i] = wr_data;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Storage array; contents are wiped by the CLEAR sweep, not by reset.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    // Read mux from the registered array only: a same-cycle write is not
    // forwarded, and unmatched (out-of-range) indices read zero.
    always_comb begin
        rd_data_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rd_data_s = (rd_idx == IDX_W'(i)) ? regs_q[i] : rd_data_s;
        end
    end

    assign rd_data = rd_data_s;

    past_shift #(
        .WIDTH (WIDTH),
        .HIST  (HIST)
    ) u_past_shift (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (rd_data_s),
        .past_data  (past_data),
        .past_valid (past_valid)
    );

`ifdef REGFILE_PAST_FORMAL_EN
    // Environment constraint, handshake exclusivity, write visibility, cover.
    always @(posedge clk) begin
        if (rst_n) begin
            m_idx: assume ({1'b0, wr_idx} < (IDX_W+1)'(DEPTH));
            a_rdy: assert (!(wr_ready && clr_busy));
            if ($past(rst_n) && $past(wr_valid && wr_ready) && (rd_idx == $past(wr_idx))) begin
                a_wr: assert (rd_data == $past(wr_data));
            end
            c_last: cover ($past(wr_valid && wr_ready && (wr_idx == IDX_W'(DEPTH - 1)))
                           && (rd_idx == IDX_W'(DEPTH - 1)));
        end
    end

    for (genvar k = 1; k <= HIST; k++) begin : g_hist
        // Each valid history slice must equal rd_data from k cycles back.
        always @(posedge clk) begin
            if (rst_n && past_valid[k-1]) begin
                a_hist: assert (past_data[(k-1)*WIDTH +: WIDTH] == $past(rd_data, k));
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_past_pipe.sv
module tb_regfile_past_pipe;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;
    localparam int HIST  = 2;
    localparam int IDX_W = 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [IDX_W-1:0]      wr_idx;
    logic [WIDTH-1:0]      wr_data;
    logic [IDX_W-1:0]      rd_idx;
    logic [WIDTH-1:0]      rd_data;
    logic [HIST*WIDTH-1:0] past_data;
    logic [HIST-1:0]       past_valid;
    logic                  clr_busy;

    regfile_past_pipe #(.DEPTH(DEPTH), .WIDTH(WIDTH), .HIST(HIST)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .past_data  (past_data),
        .past_valid (past_valid),
        .clr_busy   (clr_busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: entry contents plus "known" flags (entries untouched
    // since power-up are not compared), cycles since reset release, and the
    // list of recent read values.
    logic [WIDTH-1:0] m_regs  [DEPTH];
    bit               m_known [DEPTH];
    logic [WIDTH-1:0] m_hist  [HIST];
    bit               m_hk    [HIST];
    int               m_cyc   = 0;
    bit               m_valid = 1'b0;

    // Outputs sampled in the most recent cycle (at the falling edge).
    logic [WIDTH-1:0]      s_rd;
    logic                  s_busy, s_ready;
    logic [HIST-1:0]       s_pv;
    logic [HIST*WIDTH-1:0] s_pd;

    typedef struct {
        logic             wv;
        logic [IDX_W-1:0] wi;
        logic [WIDTH-1:0] wd;
        logic [IDX_W-1:0] ri;
        logic [WIDTH-1:0] e_rd;
        logic [WIDTH-1:0] e_p0;
        logic [WIDTH-1:0] e_p1;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model just
    // before the edge, then advance the model across the edge.
    task automatic cycle(input logic rn, input logic wv, input logic [IDX_W-1:0] wi,
                         input logic [WIDTH-1:0] wd, input logic [IDX_W-1:0] ri);
        logic [WIDTH-1:0] rd_m;
        bit               rd_k;
        rst_n    = rn;
        wr_valid = wv;
        wr_idx   = wi;
        wr_data  = wd;
        rd_idx   = ri;
        @(negedge clk);
        s_rd    = rd_data;
        s_busy  = clr_busy;
        s_ready = wr_ready;
        s_pv    = past_valid;
        s_pd    = past_data;
        rd_m    = m_regs[ri];
        rd_k    = m_known[ri];
        if (m_valid) begin
            check("clr_busy", 32'(s_busy), 32'(m_cyc < DEPTH));
            check("wr_ready", 32'(s_ready), 32'(m_cyc >= DEPTH));
            for (int k = 0; k < HIST; k++) begin
                check("past_valid", 32'(s_pv[k]), 32'(m_cyc >= k + 1));
                if (m_hk[k]) check("past_data", 32'(s_pd[k*WIDTH +: WIDTH]), 32'(m_hist[k]));
            end
            if (rd_k) check("rd_data", 32'(s_rd), 32'(rd_m));
        end
        @(posedge clk);
        if (!rn) begin
            m_valid = 1'b1;
            m_cyc   = 0;
            for (int k = 0; k < HIST; k++) begin
                m_hist[k] = '0;
                m_hk[k]   = 1'b1;
            end
        end else if (m_valid) begin
            for (int k = HIST - 1; k > 0; k--) begin
                m_hist[k] = m_hist[k-1];
                m_hk[k]   = m_hk[k-1];
            end
            m_hist[0] = rd_m;
            m_hk[0]   = rd_k;
            if (m_cyc < DEPTH) begin
                m_regs[m_cyc]  = '0;
                m_known[m_cyc] = 1'b1;
            end else if (wv) begin
                m_regs[wi]  = wd;
                m_known[wi] = 1'b1;
            end
            if (m_cyc < 100000) m_cyc++;
        end
        #1;
    endtask

    initial begin
        int busy;
        int acc;

        tbl[0] = '{1'b1, 3'd3, 8'hA5, 3'd3, 8'h00, 8'h00, 8'h00};
        tbl[1] = '{1'b0, 3'd0, 8'h00, 3'd3, 8'hA5, 8'h00, 8'h00};
        tbl[2] = '{1'b0, 3'd0, 8'h00, 3'd3, 8'hA5, 8'hA5, 8'h00};
        tbl[3] = '{1'b0, 3'd0, 8'h00, 3'd3, 8'hA5, 8'hA5, 8'hA5};
        tbl[4] = '{1'b1, 3'd5, 8'h3C, 3'd5, 8'h00, 8'hA5, 8'hA5};
        tbl[5] = '{1'b0, 3'd0, 8'h00, 3'd5, 8'h3C, 8'h00, 8'hA5};
        tbl[6] = '{1'b1, 3'd7, 8'h5A, 3'd7, 8'h00, 8'h3C, 8'h00};
        tbl[7] = '{1'b0, 3'd0, 8'h00, 3'd7, 8'h5A, 8'h00, 8'h3C};
        tbl[8] = '{1'b1, 3'd0, 8'h11, 3'd3, 8'hA5, 8'h5A, 8'h00};
        tbl[9] = '{1'b0, 3'd0, 8'h00, 3'd0, 8'h11, 8'hA5, 8'h5A};

        for (int i = 0; i < DEPTH; i++) begin
            m_regs[i]  = '0;
            m_known[i] = 1'b0;
        end
        for (int k = 0; k < HIST; k++) begin
            m_hist[k] = '0;
            m_hk[k]   = 1'b0;
        end

        // Reset state and clear sweep length.
        for (int c = 0; c < 3; c++) cycle(1'b0, 1'b0, 3'd0, 8'h00, 3'd0);
        check("rst_busy", 32'(s_busy), 32'd1);
        check("rst_ready", 32'(s_ready), 32'd0);
        check("rst_past_valid", 32'(s_pv), 32'd0);
        check("rst_past_data", 32'(s_pd), 32'd0);
        busy = 0;
        for (int c = 0; c < 12; c++) begin
            cycle(1'b1, 1'b0, 3'd0, 8'h00, 3'd0);
            if (s_busy) busy++;
        end
        check("clear_len", 32'(busy), 32'd8);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, 3'd0, 8'h00, IDX_W'(i));
            check("cleared_rd", 32'(s_rd), 32'd0);
        end

        // Table: write latency, no bypass, history slices.
        for (int r = 0; r < 10; r++) begin
            cycle(1'b1, tbl[r].wv, tbl[r].wi, tbl[r].wd, tbl[r].ri);
            check("tbl_rd", 32'(s_rd), 32'(tbl[r].e_rd));
            check("tbl_p0", 32'(s_pd[7:0]), 32'(tbl[r].e_p0));
            check("tbl_p1", 32'(s_pd[15:8]), 32'(tbl[r].e_p1));
        end

        // Write request held from reset release: accepted in cycle 9.
        cycle(1'b0, 1'b0, 3'd0, 8'h00, 3'd2);
        acc = -1;
        for (int c = 1; c <= 12; c++) begin
            cycle(1'b1, (acc < 0) ? 1'b1 : 1'b0, 3'd2, 8'h77, 3'd2);
            if (acc < 0 && s_ready) acc = c;
        end
        check("held_accept_cycle", 32'(acc), 32'd9);
        cycle(1'b1, 1'b0, 3'd0, 8'h00, 3'd2);
        check("held_rd", 32'(s_rd), 32'h77);

        // Mid-run reset pulse restarts the clear and flushes history.
        cycle(1'b1, 1'b1, 3'd1, 8'hFF, 3'd1);
        cycle(1'b1, 1'b0, 3'd0, 8'h00, 3'd1);
        check("pre_rst_rd", 32'(s_rd), 32'hFF);
        cycle(1'b0, 1'b0, 3'd0, 8'h00, 3'd1);
        cycle(1'b1, 1'b0, 3'd0, 8'h00, 3'd1);
        check("post_rst_valid", 32'(s_pv), 32'd0);
        busy = s_busy ? 1 : 0;
        for (int c = 0; c < 11; c++) begin
            cycle(1'b1, 1'b0, 3'd0, 8'h00, 3'd1);
            if (s_busy) busy++;
        end
        check("reclear_len", 32'(busy), 32'd8);
        cycle(1'b1, 1'b0, 3'd0, 8'h00, 3'd1);
        check("reclear_rd", 32'(s_rd), 32'd0);

        // Random traffic with occasional resets, checked against the model.
        for (int c = 0; c < 400; c++) begin
            cycle(($urandom_range(99) != 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(1)),
                  IDX_W'($urandom_range(DEPTH - 1)),
                  WIDTH'($urandom_range(255)),
                  IDX_W'($urandom_range(DEPTH - 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
